// File: rtl/data_memory_initiator.sv
`default_nettype none
// ============================================================================
// Module   : data_memory_initiator
// Purpose  : Core-side initiator for the phoeniX data memory bus. It places
//            store lanes, extracts and extends load data, and (with the
//            MISALIGNED_SPLIT_EN macro) splits misaligned accesses into two
//            aligned bus cycles.
// Revision : 1.0 - initial release
// ============================================================================
module data_memory_initiator #(
  parameter int ACCESS_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        request_valid,
  output logic        request_ready,
  input  logic        request_write,
  input  logic [2:0]  request_funct3,
  input  logic [31:0] request_address,
  input  logic [31:0] request_store_data,
  output logic        response_valid,
  output logic [31:0] response_load_data,
  output logic        response_error,
  output logic        memory_interface_enable,
  output logic        memory_interface_state,
  output logic [31:0] memory_interface_address,
  output logic [3:0]  memory_interface_frame_mask,
  inout  wire  [31:0] memory_interface_data
);

  localparam logic       c_READ  = 1'b0;
  localparam logic       c_WRITE = 1'b1;
  localparam logic [1:0] c_LAST  = 2'(ACCESS_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ACCESS_LO = 2'd1,
    ACCESS_HI = 2'd2,
    RESPOND   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        write_q, write_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  offset_q, offset_d;
  logic [31:0] word_addr_q, word_addr_d;
  logic [3:0]  lo_mask_q, lo_mask_d;
  logic [31:0] lo_data_q, lo_data_d;
  logic        error_q, error_d;
  logic [31:0] result_q, result_d;
`ifdef MISALIGNED_SPLIT_EN
  logic        split_q, split_d;
  logic [3:0]  hi_mask_q, hi_mask_d;
  logic [31:0] hi_data_q, hi_data_d;
  logic [31:0] lo_rdata_q, lo_rdata_d;
`endif

  logic [1:0]  w_offset;
  logic [2:0]  w_size;
  logic [3:0]  w_size_lanes;
  logic [2:0]  w_end;
  logic        w_legal;
  logic        w_split;
  logic [3:0]  w_lo_lanes;
  logic [31:0] w_lo_data;
  logic [31:0] w_rd_aligned;
  logic        w_drive_en;
  logic [31:0] w_drive_data;
`ifdef MISALIGNED_SPLIT_EN
  logic [3:0]  w_hi_lanes;
  logic [31:0] w_hi_data;
  logic [63:0] w_join;
  logic [31:0] w_rd_split;
`endif

  // Lane L (bits [8L+7:8L]) is enabled by frame mask bit 3-L.
  function automatic logic [3:0] lanes_to_mask(input logic [3:0] lanes);
    return {lanes[0], lanes[1], lanes[2], lanes[3]};
  endfunction

  function automatic logic [31:0] extend_load(input logic [2:0] f3, input logic [31:0] raw);
    case (f3)
      3'd0:    extend_load = {{24{raw[7]}}, raw[7:0]};
      3'd1:    extend_load = {{16{raw[15]}}, raw[15:0]};
      3'd4:    extend_load = {24'd0, raw[7:0]};
      3'd5:    extend_load = {16'd0, raw[15:0]};
      default: extend_load = raw;
    endcase
  endfunction

  always_comb begin
    w_offset = request_address[1:0];
    w_legal  = (request_funct3 != 3'd3) && (request_funct3 != 3'd6) && (request_funct3 != 3'd7);
    case (request_funct3[1:0])
      2'd0:    begin w_size = 3'd1; w_size_lanes = 4'b0001; end
      2'd1:    begin w_size = 3'd2; w_size_lanes = 4'b0011; end
      default: begin w_size = 3'd4; w_size_lanes = 4'b1111; end
    endcase
    w_end      = {1'b0, w_offset} + w_size;
    w_split    = (w_end > 3'd4);
    w_lo_lanes = w_size_lanes << w_offset;
    w_lo_data  = request_store_data << {w_offset, 3'b000};
`ifdef MISALIGNED_SPLIT_EN
    // Bytes that spill past lane 3 continue from lane 0 of the next word.
    w_hi_lanes = w_size_lanes >> (3'd4 - {1'b0, w_offset});
    w_hi_data  = request_store_data >> (6'd32 - {1'b0, w_offset, 3'b000});
`endif
  end

  assign w_rd_aligned = memory_interface_data >> {offset_q, 3'b000};
`ifdef MISALIGNED_SPLIT_EN
  assign w_join     = {memory_interface_data, lo_rdata_q};
  assign w_rd_split = w_join[{1'b0, offset_q, 3'b000} +: 32];
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    write_d     = write_q;
    funct3_d    = funct3_q;
    offset_d    = offset_q;
    word_addr_d = word_addr_q;
    lo_mask_d   = lo_mask_q;
    lo_data_d   = lo_data_q;
    error_d     = error_q;
    result_d    = result_q;
`ifdef MISALIGNED_SPLIT_EN
    split_d     = split_q;
    hi_mask_d   = hi_mask_q;
    hi_data_d   = hi_data_q;
    lo_rdata_d  = lo_rdata_q;
`endif
    case (state_q)
      IDLE: begin
        if (request_valid) begin
          write_d     = request_write;
          funct3_d    = request_funct3;
          offset_d    = w_offset;
          word_addr_d = {request_address[31:2], 2'b00};
          lo_mask_d   = lanes_to_mask(w_lo_lanes);
          lo_data_d   = w_lo_data;
          cnt_d       = 2'd0;
          result_d    = 32'd0;
          error_d     = 1'b0;
`ifdef MISALIGNED_SPLIT_EN
          split_d     = w_split;
          hi_mask_d   = lanes_to_mask(w_hi_lanes);
          hi_data_d   = w_hi_data;
          if (!w_legal) begin
`else
          if (!w_legal || w_split) begin
`endif
            error_d = 1'b1;
            state_d = RESPOND;
          end else begin
            state_d = ACCESS_LO;
          end
        end
      end
      ACCESS_LO: begin
        if (cnt_q == c_LAST) begin
          cnt_d = 2'd0;
`ifdef MISALIGNED_SPLIT_EN
          if (split_q) begin
            lo_rdata_d = memory_interface_data;
            state_d    = ACCESS_HI;
          end else begin
`endif
            result_d = write_q ? 32'd0 : extend_load(funct3_q, w_rd_aligned);
            state_d  = RESPOND;
`ifdef MISALIGNED_SPLIT_EN
          end
`endif
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
`ifdef MISALIGNED_SPLIT_EN
      ACCESS_HI: begin
        if (cnt_q == c_LAST) begin
          cnt_d    = 2'd0;
          result_d = write_q ? 32'd0 : extend_load(funct3_q, w_rd_split);
          state_d  = RESPOND;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
`endif
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 2'd0;
      write_q     <= 1'b0;
      funct3_q    <= 3'd0;
      offset_q    <= 2'd0;
      word_addr_q <= 32'd0;
      lo_mask_q   <= 4'd0;
      lo_data_q   <= 32'd0;
      error_q     <= 1'b0;
      result_q    <= 32'd0;
`ifdef MISALIGNED_SPLIT_EN
      split_q     <= 1'b0;
      hi_mask_q   <= 4'd0;
      hi_data_q   <= 32'd0;
      lo_rdata_q  <= 32'd0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      write_q     <= write_d;
      funct3_q    <= funct3_d;
      offset_q    <= offset_d;
      word_addr_q <= word_addr_d;
      lo_mask_q   <= lo_mask_d;
      lo_data_q   <= lo_data_d;
      error_q     <= error_d;
      result_q    <= result_d;
`ifdef MISALIGNED_SPLIT_EN
      split_q     <= split_d;
      hi_mask_q   <= hi_mask_d;
      hi_data_q   <= hi_data_d;
      lo_rdata_q  <= lo_rdata_d;
`endif
    end
  end

  // Bus signals decode straight from the state register so reset releases them at once.
  always_comb begin
    request_ready               = (state_q == IDLE);
    response_valid              = (state_q == RESPOND);
    response_error              = response_valid & error_q;
    response_load_data          = response_valid ? result_q : 32'd0;
    memory_interface_enable     = 1'b0;
    memory_interface_state      = c_READ;
    memory_interface_address    = 32'd0;
    memory_interface_frame_mask = 4'd0;
    w_drive_en                  = 1'b0;
    w_drive_data                = lo_data_q;
    case (state_q)
      ACCESS_LO: begin
        memory_interface_enable     = 1'b1;
        memory_interface_state      = write_q ? c_WRITE : c_READ;
        memory_interface_address    = word_addr_q;
        memory_interface_frame_mask = lo_mask_q;
        w_drive_en                  = write_q;
      end
`ifdef MISALIGNED_SPLIT_EN
      ACCESS_HI: begin
        memory_interface_enable     = 1'b1;
        memory_interface_state      = write_q ? c_WRITE : c_READ;
        memory_interface_address    = word_addr_q + 32'd4;
        memory_interface_frame_mask = hi_mask_q;
        w_drive_en                  = write_q;
        w_drive_data                = hi_data_q;
      end
`endif
      default: ;
    endcase
  end

  assign memory_interface_data = w_drive_en ? w_drive_data : 32'hzzzz_zzzz;

endmodule
`default_nettype wire

// File: tb/tb_data_memory_initiator.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_memory_initiator
// Purpose  : Self-checking bench for data_memory_initiator: byte-level memory
//            reference model, negedge-sampling bus memory, random requests.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_memory_initiator;

  localparam int   LAT     = 3;
  localparam logic READ_C  = 1'b0;
  localparam logic WRITE_C = 1'b1;

  typedef logic [68:0] cv_t;
  typedef struct packed {
    logic [31:0] a;
    logic [3:0]  m;
    logic        w;
    logic [31:0] d;
  } cyc_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        request_valid = 1'b0;
  logic        request_write = 1'b0;
  logic [2:0]  request_funct3 = 3'd0;
  logic [31:0] request_address = 32'd0;
  logic [31:0] request_store_data = 32'd0;
  logic        request_ready;
  logic        response_valid;
  logic [31:0] response_load_data;
  logic        response_error;
  logic        memory_interface_enable;
  logic        memory_interface_state;
  logic [31:0] memory_interface_address;
  logic [3:0]  memory_interface_frame_mask;
  wire  [31:0] mem_bus;
  wire         mem_oe;

  logic        probe_oe = 1'b0;
  logic [31:0] mem_drive = 32'd0;
  logic [7:0]  bus_mem [logic [31:0]];
  logic [7:0]  ref_mem [logic [31:0]];
  cyc_t        bus_log [$];
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  data_memory_initiator #(.ACCESS_LATENCY(LAT)) u_dut (
    .clk                         (clk),
    .reset                       (reset),
    .request_valid               (request_valid),
    .request_ready               (request_ready),
    .request_write               (request_write),
    .request_funct3              (request_funct3),
    .request_address             (request_address),
    .request_store_data          (request_store_data),
    .response_valid              (response_valid),
    .response_load_data          (response_load_data),
    .response_error              (response_error),
    .memory_interface_enable     (memory_interface_enable),
    .memory_interface_state      (memory_interface_state),
    .memory_interface_address    (memory_interface_address),
    .memory_interface_frame_mask (memory_interface_frame_mask),
    .memory_interface_data       (mem_bus)
  );

  // The bench drives the bus only for read cycles, or with zeros when probing release.
  assign mem_oe  = probe_oe || (memory_interface_enable && (memory_interface_state == READ_C));
  assign mem_bus = mem_oe ? (probe_oe ? 32'h0 : mem_drive) : 32'hzzzz_zzzz;

  task automatic chk(input string tag, input cv_t got, input cv_t exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] bus_rd(input logic [31:0] a);
    return bus_mem.exists(a) ? bus_mem[a] : 8'h00;
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  function automatic void preload(input logic [31:0] a, input logic [7:0] v);
    bus_mem[a] = v;
    ref_mem[a] = v;
  endfunction

  // Memory side of the bus: samples on negedge, presents read data until the next posedge.
  always @(negedge clk) begin
    cyc_t c;
    if (memory_interface_enable) begin
      c.a = memory_interface_address;
      c.m = memory_interface_frame_mask;
      c.w = memory_interface_state;
      c.d = 32'd0;
      for (int l = 0; l < 4; l++) begin
        if (memory_interface_frame_mask[3-l] && memory_interface_state == WRITE_C) begin
          bus_mem[memory_interface_address + l] = mem_bus[8*l +: 8];
          c.d[8*l +: 8] = mem_bus[8*l +: 8];
        end
      end
      mem_drive = {bus_rd(memory_interface_address + 32'd3), bus_rd(memory_interface_address + 32'd2),
                   bus_rd(memory_interface_address + 32'd1), bus_rd(memory_interface_address)};
      bus_log.push_back(c);
    end
  end

  task automatic do_req(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] sd, output logic [31:0] ld, output logic er);
    int          s;
    int          o;
    int          cyc;
    int          exp_lat;
    logic        split;
    logic        exp_err;
    logic [31:0] exp_ld;
    cyc_t        exp_q [$];
    cyc_t        cur;
    s       = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    o       = int'(a[1:0]);
    split   = (o + s > 4);
    exp_err = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
`ifndef MISALIGNED_SPLIT_EN
    if (split) exp_err = 1'b1;
`endif
    exp_ld = 32'd0;
    cur    = '0;
    if (!exp_err) begin
      // Walk the request byte by byte; each new word address opens a new bus cycle.
      for (int i = 0; i < s; i++) begin
        logic [31:0] b;
        logic [31:0] wa;
        int          l;
        b  = a + i;
        wa = b & ~32'h3;
        l  = int'(b[1:0]);
        if (i == 0 || wa != cur.a) begin
          if (i != 0) exp_q.push_back(cur);
          cur.a = wa; cur.m = 4'd0; cur.w = wr; cur.d = 32'd0;
        end
        cur.m[3-l] = 1'b1;
        if (wr) begin
          cur.d[8*l +: 8] = sd[8*i +: 8];
          ref_mem[b]      = sd[8*i +: 8];
        end else begin
          exp_ld[8*i +: 8] = ref_rd(b);
        end
      end
      exp_q.push_back(cur);
      if (!wr && f3 == 3'd0 && exp_ld[7])  exp_ld = exp_ld | 32'hFFFF_FF00;
      if (!wr && f3 == 3'd1 && exp_ld[15]) exp_ld = exp_ld | 32'hFFFF_0000;
    end
    exp_lat = exp_err ? 1 : exp_q.size() * LAT + 1;

    bus_log.delete();
    @(negedge clk);
    chk("ready_idle", cv_t'(request_ready), cv_t'(1'b1));
    request_valid      = 1'b1;
    request_write      = wr;
    request_funct3     = f3;
    request_address    = a;
    request_store_data = sd;
    @(posedge clk); #1;
    request_valid      = 1'b0;
    request_write      = 1'($urandom);
    request_funct3     = 3'($urandom);
    request_address    = $urandom;
    request_store_data = $urandom;
    cyc = 1;
    while (!response_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("latency", cv_t'(cyc), cv_t'(exp_lat));
    chk("resp_valid", cv_t'(response_valid), cv_t'(1'b1));
    chk("resp_error", cv_t'(response_error), cv_t'(exp_err));
    chk("resp_data", cv_t'(response_load_data), cv_t'(exp_ld));
    chk("ready_busy", cv_t'(request_ready), cv_t'(1'b0));
    chk("enable_resp", cv_t'(memory_interface_enable), cv_t'(1'b0));
    ld = response_load_data;
    er = response_error;
    chk("bus_cycles", cv_t'(bus_log.size()), cv_t'(exp_q.size() * LAT));
    for (int k = 0; k < exp_q.size() * LAT && k < bus_log.size(); k++)
      chk("bus_cycle", cv_t'(bus_log[k]), cv_t'(exp_q[k / LAT]));
    @(posedge clk); #1;
    chk("resp_pulse", cv_t'(response_valid), cv_t'(1'b0));
  endtask

  initial begin
    logic [31:0] ld;
    logic        er;

    for (int i = 0; i < 40; i++) preload(32'h100 + i, 8'($urandom));
    for (int i = 0; i < 8; i++) begin
      preload(32'hFFFF_FFF8 + i, 8'($urandom));
      preload(32'h0 + i, 8'($urandom));
    end
    preload(32'h1FC, 8'h11); preload(32'h1FD, 8'h22); preload(32'h1FE, 8'h33); preload(32'h1FF, 8'h44);
    preload(32'h200, 8'h55); preload(32'h201, 8'h66); preload(32'h202, 8'h77); preload(32'h203, 8'h88);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", cv_t'(request_ready), cv_t'(1'b1));
    chk("rst_rvalid", cv_t'(response_valid), cv_t'(1'b0));
    chk("rst_rdata", cv_t'(response_load_data), cv_t'(32'd0));
    chk("rst_rerror", cv_t'(response_error), cv_t'(1'b0));
    chk("rst_enable", cv_t'(memory_interface_enable), cv_t'(1'b0));
    chk("rst_state", cv_t'(memory_interface_state), cv_t'(READ_C));
    chk("rst_addr", cv_t'(memory_interface_address), cv_t'(32'd0));
    chk("rst_mask", cv_t'(memory_interface_frame_mask), cv_t'(4'd0));
    @(negedge clk);
    reset = 1'b0;

    do_req(1'b1, 3'd2, 32'h100, 32'hDEAD_BEEF, ld, er);
    do_req(1'b0, 3'd2, 32'h100, 32'h0, ld, er);
    chk("lw_100", cv_t'(ld), cv_t'(32'hDEAD_BEEF));
    do_req(1'b1, 3'd0, 32'h103, 32'h0000_005A, ld, er);
    do_req(1'b0, 3'd0, 32'h103, 32'h0, ld, er);
    chk("lb_5a", cv_t'(ld), cv_t'(32'h0000_005A));
    do_req(1'b1, 3'd0, 32'h103, 32'h0000_0080, ld, er);
    do_req(1'b0, 3'd0, 32'h103, 32'h0, ld, er);
    chk("lb_80", cv_t'(ld), cv_t'(32'hFFFF_FF80));
    do_req(1'b0, 3'd4, 32'h103, 32'h0, ld, er);
    chk("lbu_80", cv_t'(ld), cv_t'(32'h0000_0080));
    do_req(1'b1, 3'd1, 32'h102, 32'h0000_8001, ld, er);
    do_req(1'b0, 3'd1, 32'h102, 32'h0, ld, er);
    chk("lh_8001", cv_t'(ld), cv_t'(32'hFFFF_8001));
    do_req(1'b0, 3'd5, 32'h102, 32'h0, ld, er);
    chk("lhu_8001", cv_t'(ld), cv_t'(32'h0000_8001));
    do_req(1'b0, 3'd2, 32'h1FE, 32'h0, ld, er);
`ifdef MISALIGNED_SPLIT_EN
    chk("lw_split", cv_t'({er, ld}), cv_t'({1'b0, 32'h6655_4433}));
`else
    chk("lw_split_err", cv_t'({er, ld}), cv_t'({1'b1, 32'h0}));
`endif
    do_req(1'b0, 3'd3, 32'h104, 32'h0, ld, er);
    chk("f3_illegal", cv_t'(er), cv_t'(1'b1));
    do_req(1'b1, 3'd2, 32'hFFFF_FFFE, 32'hCAFE_F00D, ld, er);
    do_req(1'b0, 3'd2, 32'hFFFF_FFFE, 32'h0, ld, er);

    for (int n = 0; n < 250; n++) begin
      logic [31:0] a;
      if ($urandom_range(0, 9) == 0) a = 32'hFFFF_FFFC + $urandom_range(0, 3);
      else                           a = 32'h100 + $urandom_range(0, 31);
      do_req(1'($urandom), 3'($urandom_range(0, 7)), a, $urandom, ld, er);
    end

    // Abort a store while it is driving the bus.
    @(negedge clk);
    request_valid      = 1'b1;
    request_write      = 1'b1;
    request_funct3     = 3'd2;
    request_address    = 32'h108;
    request_store_data = 32'hA5C3_96F0;
    @(posedge clk); #1;
    request_valid = 1'b0;
    chk("abort_enable_on", cv_t'(memory_interface_enable), cv_t'(1'b1));
    chk("abort_bus_driven", cv_t'(mem_bus), cv_t'(32'hA5C3_96F0));
    #1 reset = 1'b1;
    #1;
    chk("abort_enable_off", cv_t'(memory_interface_enable), cv_t'(1'b0));
    chk("abort_ready", cv_t'(request_ready), cv_t'(1'b1));
    chk("abort_addr", cv_t'(memory_interface_address), cv_t'(32'd0));
    chk("abort_mask", cv_t'(memory_interface_frame_mask), cv_t'(4'd0));
    chk("abort_state", cv_t'(memory_interface_state), cv_t'(READ_C));
    probe_oe = 1'b1;
    #1;
    chk("abort_bus_release", cv_t'(mem_bus), cv_t'(32'h0));
    probe_oe = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < LAT + 2; k++) begin
      @(posedge clk); #1;
      chk("abort_no_resp", cv_t'(response_valid), cv_t'(1'b0));
      chk("abort_idle", cv_t'(request_ready), cv_t'(1'b1));
    end
    do_req(1'b0, 3'd2, 32'h108, 32'h0, ld, er);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/data_memory_initiator.md
# data_memory_initiator

Synthesizable initiator for the phoeniX data memory interface: it turns load/store requests from the core's memory stage into enable/state/address/frame-mask/data bus cycles. It places store bytes on the correct lanes and extracts and extends load data. Misaligned accesses can optionally be split into two aligned bus cycles. It is the core-side counterpart of the memory model that answers on this interface, and it sits between the execute/memory pipeline registers and the external data memory.

## Interface
- `ACCESS_LATENCY`, default 1: cycles `memory_interface_enable` is held per bus cycle before read data is captured; legal range 1..4.
- `clk`  in  1  core clock.
- `reset`  in  1  asynchronous, active-high reset.
- `request_valid`  in  1  request present.
- `request_ready`  out  1  high only in IDLE; a request is accepted on a posedge with valid && ready.
- `request_write`  in  1  1 = store, 0 = load.
- `request_funct3`  in  3  RISC-V width code: 0 LB/SB, 1 LH/SH, 2 LW/SW, 4 LBU, 5 LHU.
- `request_address`  in  32  byte address.
- `request_store_data`  in  32  store data, right-aligned.
- `response_valid`  out  1  one-cycle completion pulse.
- `response_load_data`  out  32  extended load result; 0 for stores and errors.
- `response_error`  out  1  qualifies `response_valid`: illegal funct3 or unsupported misalignment.
- `memory_interface_enable`  out  1  bus cycle active.
- `memory_interface_state`  out  1  `READ`/`WRITE` codes of the codebase.
- `memory_interface_address`  out  32  word-aligned address, bits [1:0] = 0.
- `memory_interface_frame_mask`  out  4  lane enables; bit 3 = bits [7:0], bit 0 = bits [31:24].
- `memory_interface_data`  inout  32  driven with lane-placed store data during WRITE cycles; high-Z otherwise.

## Operation
- States: IDLE, ACCESS_LO, ACCESS_HI, RESPOND.
- IDLE → ACCESS_LO on accept. The request is latched, so inputs may change afterwards.
- An illegal funct3 (3, 6, 7) goes IDLE → RESPOND with `response_error`=1 and no bus cycle.
- Offset o = address[1:0], size s = 1/2/4 bytes.
- Lane L holds request byte (L−o) and is enabled via mask bit (3−L).
- Aligned means o+s ≤ 4. Aligned access: ACCESS_LO only, then RESPOND.
- Split access (o+s > 4):
  - ACCESS_LO covers word A, lanes o..3.
  - ACCESS_HI covers word A+4, lanes 0..o+s−5.
  - Bytes are reassembled in request order.
- Load result:
  - The assembled bytes are shifted right by 8·o.
  - funct3 0/1 sign-extend from bit 7/15.
  - funct3 4/5 zero-extend.
- Address wrap: A+4 at 0xFFFF_FFFC wraps to 0x0000_0000.
- RESPOND lasts exactly one cycle, then returns to IDLE.

## Timing
- Reset values (applied immediately, asynchronously):
  - state IDLE, `request_ready`=1.
  - `response_valid`=0, `response_load_data`=0, `response_error`=0.
  - `memory_interface_enable`=0, `memory_interface_state`=`READ`, address 0, mask 0.
  - data bus high-Z.
- Each ACCESS state holds enable, state, address, mask and data stable for `ACCESS_LATENCY` cycles.
- Memory samples on negedge. Read data is valid from negedge to the next posedge, so it is captured on the posedge that ends the last cycle of the access state.
- Latency from the accept edge to `response_valid`:
  - aligned: `ACCESS_LATENCY`+1 cycles.
  - split: 2·`ACCESS_LATENCY`+1 cycles.
- `memory_interface_enable` goes low in RESPOND. There is no idle gap between ACCESS_LO and ACCESS_HI.
- A `request_valid` arriving during RESPOND is not accepted until the following IDLE cycle.
- Reset mid-access aborts without a response. Partially completed split stores are not rolled back.

## Configuration
- `MISALIGNED_SPLIT_EN` defined: split behaviour as described; ACCESS_HI exists.
- `MISALIGNED_SPLIT_EN` undefined:
  - Any o+s > 4 request goes IDLE → RESPOND with `response_error`=1 and data 0, and no bus cycle is issued.
  - ACCESS_HI is not synthesized.

## Test plan
- Aligned SW 0xDEADBEEF @0x100, then LW @0x100 → mask 4'b1111 on address 0x100; load returns 0xDEADBEEF with `response_valid` 2 cycles after accept (`ACCESS_LATENCY`=1).
- SB 0x5A @0x103, then LB @0x103 → mask 4'b0001, bus bits [31:24]=0x5A; LB returns 0x0000005A. With memory byte 0x80, LB → 0xFFFFFF80 and LBU → 0x00000080.
- LH @0x102 on word 0x8001_xxxx → mask 4'b0011; returns 0xFFFF8001. LHU returns 0x00008001.
- With `MISALIGNED_SPLIT_EN`: LW @0x1FE on memory words 0x1FC=0x4433_2211, 0x200=0x8877_6655 → two bus cycles, masks 4'b0011 then 4'b1100; result 0x6655_4433; `response_valid` 3 cycles after accept. Without the macro → `response_error`=1, no enable pulse.
- funct3=3 request → `response_error`=1 one cycle after accept, enable never asserted.
- `reset` asserted mid-ACCESS_LO with `ACCESS_LATENCY`=3 → enable drops and the data bus releases in the same cycle; no `response_valid`; `request_ready`=1 after release.
